mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Multi-cycle multiply/divide unit in the execute stage, beside the ALU. It takes the same forwarded operands (A, B) and owns the architectural HI/LO registers. It implements MULT/MULTU/DIV/DIVU/MTHI/MTLO and raises busy so the hazard unit stalls MFHI/MFLO and further mult/div issue. Results are read through the execute result mux alongside the ALU output.

Parameters:
MULT_CYCLES, 5, cycles busy is high for MULT/MULTU (>=1)
DIV_CYCLES, 10, cycles busy is high for DIV/DIVU (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  issue strobe; op/A/B sampled on the edge where start=1
op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
A  input  32  rs operand (dividend / multiplicand / MTHI,MTLO source)
B  input  32  rt operand (divisor / multiplier)
cancel  input  1  exception flush; aborts any in-flight operation
busy  output  1  operation in flight
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset_n=0, asynchronous): hi=0, lo=0, busy=0, state IDLE, counter=0, shadow result=0.
- States: IDLE, MUL, DIV. Counter counts remaining cycles.
- IDLE + start + op MULT/MULTU: latch 64-bit product into shadow (MULT signed x signed, MULTU unsigned), counter=MULT_CYCLES, go MUL.
- IDLE + start + op DIV/DIVU: if B==0, no state change, stay IDLE, hi/lo unchanged, busy stays 0. Else latch quotient->shadow low, remainder->shadow high, counter=DIV_CYCLES, go DIV.
- Signed divide: quotient truncates toward zero, remainder takes the dividend's sign. 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- IDLE + start + MTHI: hi<=A at that edge. MTLO: lo<=A. No busy. Both take effect in one cycle.
- IDLE + start + op NONE/7: no effect.
- MUL/DIV: counter decrements each edge. On the edge where counter reaches 0: {hi,lo}<=shadow and state goes IDLE. busy=1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), from the cycle after issue. New hi/lo are visible in the first cycle with busy=0.
- busy is a registered output (state != IDLE); it is not combinational on start. The hazard unit stalls on (busy | start&&op in 1..4).
- start while busy: ignored entirely, including MTHI/MTLO. The pipeline must not issue it; the bench checks that it is ignored.
- cancel (synchronous, highest priority after reset): state goes IDLE, busy=0, hi/lo unchanged. If start and cancel are both high on the same edge, start is ignored. Cancel on the completing edge: the commit is suppressed.
- Reset asserted mid-operation: immediate return to reset values. No partial commit.
- hi/lo are stable at all times except the commit or MTHI/MTLO edge.

Test Plan:
- MULT A=0xFFFFFFFE(-2), B=0x00000003, start 1 cycle -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x1234 via MTHI and lo=0x5678 via MTLO (each visible the next cycle), then DIV B=0 -> busy never rises; hi/lo stay 0x1234/0x5678.
- Issue MULT, then on cycle 2 of busy pulse start with MTLO A=0xDEAD -> ignored; lo ends as the product and busy still totals 5 cycles.
- Issue DIV, assert cancel on cycle 4 -> busy drops the next cycle and hi/lo keep prior values. Repeat with cancel on the completing edge -> no commit.
- Drop reset_n asynchronously mid-MULT, between clock edges -> busy, hi and lo read 0 immediately. After release, a new MULTU 3x4 gives lo=12, hi=0 after 5 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// The result is computed at issue and held in a shadow register until the busy window expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [63:0] shadow, prod;
  logic [31:0] ua, ub, ud, uq, ur, q, r;
  logic sgn, idle_go, issue_mul, issue_div, commit;
  always_comb begin
    sgn = op == 3'd1 || op == 3'd3;
    idle_go = state == IDLE && start && !cancel;
    issue_mul = idle_go && (op == 3'd1 || op == 3'd2);
    issue_div = idle_go && (op == 3'd3 || op == 3'd4) && B != 32'd0;
    prod = {{32{sgn & A[31]}}, A} * {{32{sgn & B[31]}}, B};
    // Signed divide runs on magnitudes, so INT_MIN / -1 cannot overflow.
    ua = sgn && A[31] ? -A : A;
    ub = sgn && B[31] ? -B : B;
    ud = ub == 32'd0 ? 32'd1 : ub;
    uq = ua / ud;
    ur = ua % ud;
    q = sgn && (A[31] ^ B[31]) ? -uq : uq;
    r = sgn && A[31] ? -ur : ur;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = cancel ? IDLE : issue_mul ? MUL : issue_div ? DIV :
              (state != IDLE && cnt == CW'(1)) ? IDLE : state;
  always_comb begin
    busy = state != IDLE;
    commit = busy && cnt == CW'(1) && !cancel;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      shadow <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      cnt <= cancel ? '0 : issue_mul ? CW'(MULT_CYCLES) : issue_div ? CW'(DIV_CYCLES) :
             busy ? cnt - CW'(1) : cnt;
      shadow <= issue_mul ? prod : issue_div ? {r, q} : shadow;
      hi <= commit ? shadow[63:32] : (idle_go && op == 3'd5) ? A : hi;
      lo <= commit ? shadow[31:0] : (idle_go && op == 3'd6) ? A : lo;
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed plan cases plus random traffic, checked every cycle
// against an arithmetic model of HI/LO and the busy window.
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 0, reset_n = 0, start = 0, cancel = 0;
  logic [2:0] op = 0;
  logic [31:0] A = 0, B = 0;
  logic busy;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_res = 0;
  int m_left = 0;
  int n;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: return sa * sb;
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: return {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_hi = 0; m_lo = 0; m_res = 0; m_left = 0;
    end else if (cancel) m_left = 0;
    else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_res;
    end else if (start) begin
      if (op == 3'd1 || op == 3'd2) begin
        m_res = ref_result(op, A, B);
        m_left = MC;
      end else if ((op == 3'd3 || op == 3'd4) && B != 0) begin
        m_res = ref_result(op, A, B);
        m_left = DC;
      end else if (op == 3'd5) m_hi = A;
      else if (op == 3'd6) m_lo = A;
    end

  always @(negedge clk) begin
    chk("model_busy", 32'(busy), 32'(m_left > 0));
    chk("model_hi", hi, m_hi);
    chk("model_lo", lo, m_lo);
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 0; op = 0; A = $urandom; B = $urandom;
  endtask

  task automatic run_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
      cnt++;
    end
    checks++;
    errors++;
    $display("FAIL busy_timeout got busy=1 want busy=0 within 200 cycles");
  endtask

  task automatic expect_done(input string nm, input int cyc, input logic [31:0] h, input logic [31:0] l);
    int c;
    run_busy(c);
    chk({nm, "_cycles"}, 32'(c), 32'(cyc));
    chk({nm, "_hi"}, hi, h);
    chk({nm, "_lo"}, lo, l);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    #2 reset_n = 1;

    issue(3'd1, 32'hFFFFFFFE, 32'h3);
    expect_done("mult", MC, 32'hFFFFFFFF, 32'hFFFFFFFA);
    issue(3'd2, 32'hFFFFFFFE, 32'h3);
    expect_done("multu", MC, 32'h2, 32'hFFFFFFFA);
    issue(3'd3, 32'hFFFFFFF9, 32'h2);
    expect_done("div", DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'd4, 32'h7, 32'h2);
    expect_done("divu", DC, 32'h1, 32'h3);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    expect_done("div_ovf", DC, 32'h0, 32'h80000000);

    issue(3'd5, 32'h1234, 0);
    @(negedge clk);
    chk("mthi", hi, 32'h1234);
    issue(3'd6, 32'h5678, 0);
    @(negedge clk);
    chk("mtlo", lo, 32'h5678);
    issue(3'd3, 32'd100, 32'd0);
    expect_done("div0", 0, 32'h1234, 32'h5678);
    repeat (3) begin
      @(negedge clk);
      chk("div0_idle", 32'(busy), 0);
    end

    issue(3'd1, 32'd6, 32'd7);
    n = 0;
    @(negedge clk); n += 32'(busy);
    @(posedge clk); #1;
    start = 1; op = 3'd6; A = 32'hDEAD;
    @(negedge clk); n += 32'(busy);
    @(posedge clk); #1;
    start = 0; op = 0;
    begin
      int rest;
      run_busy(rest);
      n += rest;
    end
    chk("mtlo_busy_cycles", 32'(n), MC);
    chk("mtlo_busy_lo", lo, 32'd42);
    chk("mtlo_busy_hi", hi, 32'd0);

    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 cancel = 1;
    @(posedge clk); #1 cancel = 0;
    @(negedge clk);
    chk("cancel4_busy", 32'(busy), 0);
    chk("cancel4_hi", hi, 32'd0);
    chk("cancel4_lo", lo, 32'd42);

    issue(3'd3, 32'd100, 32'd7);
    repeat (DC - 1) @(posedge clk);
    #1 cancel = 1;
    @(posedge clk); #1 cancel = 0;
    @(negedge clk);
    chk("cancel_last_busy", 32'(busy), 0);
    chk("cancel_last_hi", hi, 32'd0);
    chk("cancel_last_lo", lo, 32'd42);

    @(posedge clk); #1;
    start = 1; op = 3'd5; A = 32'hFFFF; cancel = 1;
    @(posedge clk); #1;
    start = 0; op = 0; cancel = 0;
    @(negedge clk);
    chk("cancel_start_hi", hi, 32'd0);

    issue(3'd5, 32'hAAAA, 0);
    issue(3'd1, 32'd5, 32'd6);
    @(posedge clk); #3 reset_n = 0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_hi", hi, 0);
    chk("async_rst_lo", lo, 0);
    @(negedge clk); #2 reset_n = 1;
    issue(3'd2, 32'd3, 32'd4);
    expect_done("post_rst", MC, 32'd0, 32'd12);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = ($urandom % 3) == 0;
      op = 3'($urandom % 8);
      A = ($urandom % 10 == 0) ? 32'h80000000 : $urandom;
      B = ($urandom % 8 == 0) ? 32'd0 : ($urandom % 5 == 0) ? 32'hFFFFFFFF : $urandom;
      cancel = ($urandom % 25) == 0;
    end
    @(posedge clk); #1;
    start = 0; cancel = 0; op = 0;
    repeat (DC + 3) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
